// File: rtl/sram_bus_arbiter_if.sv
// Signal bundle between the pipeline ports, the SRAM bus and sram_bus_arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface sram_bus_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic              inst_req;
    logic [AW-1:0]     inst_addr;
    logic              inst_done;
    logic [DW-1:0]     inst_rdata;

    logic              data_req;
    logic              data_we;
    logic [AW-1:0]     data_addr;
    logic [DW/8-1:0]   data_sel;
    logic [DW-1:0]     data_wdata;
    logic              data_done;
    logic [DW-1:0]     data_rdata;

    logic              bus_req;
    logic              bus_we;
    logic [AW-1:0]     bus_addr;
    logic [DW/8-1:0]   bus_sel;
    logic [DW-1:0]     bus_wdata;
    logic              bus_ack;
    logic [DW-1:0]     bus_rdata;
    logic              bus_err;

    logic              stallreq_for_bus;

    modport slave (
        input  inst_req, inst_addr,
        input  data_req, data_we, data_addr, data_sel, data_wdata,
        input  bus_ack, bus_rdata,
        output inst_done, inst_rdata,
        output data_done, data_rdata,
        output bus_req, bus_we, bus_addr, bus_sel, bus_wdata, bus_err,
        output stallreq_for_bus
    );

    modport master (
        output inst_req, inst_addr,
        output data_req, data_we, data_addr, data_sel, data_wdata,
        output bus_ack, bus_rdata,
        input  inst_done, inst_rdata,
        input  data_done, data_rdata,
        input  bus_req, bus_we, bus_addr, bus_sel, bus_wdata, bus_err,
        input  stallreq_for_bus
    );
endinterface

// File: rtl/sram_bus_arbiter.sv
// Round-robin arbiter sharing one SRAM bus between instruction fetch and load/store.
// Optional busy watchdog enabled by defining SRAM_BUS_TIMEOUT_EN.
module sram_bus_arbiter #(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic             clk,
    input logic             rst,
    sram_bus_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] INST_BUSY = 2'd1;
    localparam logic [1:0] DATA_BUSY = 2'd2;

    logic [1:0]      state;
    logic [1:0]      state_next;
    logic            last_grant;
    logic            we_q;
    logic [AW-1:0]   addr_q;
    logic [DW/8-1:0] sel_q;
    logic [DW-1:0]   wdata_q;
    logic [DW-1:0]   inst_rdata_q;
    logic [DW-1:0]   data_rdata_q;
    logic            grant_inst;
    logic            grant_data;
    logic            busy;
    logic            timeout;
    logic            finish;
    logic            inst_fin;
    logic            data_fin;
    logic [DW-1:0]   rdata_now;

    assign busy = (state == INST_BUSY) || (state == DATA_BUSY);

    // On a tie the port that did not win last time is granted.
    always_comb begin
        grant_inst = 1'b0;
        grant_data = 1'b0;
        if (state == IDLE) begin
            if (bus.inst_req && bus.data_req) begin
                grant_inst = last_grant;
                grant_data = !last_grant;
            end else begin
                grant_inst = bus.inst_req;
                grant_data = bus.data_req;
            end
        end
    end

`ifdef SRAM_BUS_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] busy_cnt;

    // Loaded with 1 on grant so the count equals the current busy-cycle number.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_cnt <= '0;
        end else if (grant_inst || grant_data) begin
            busy_cnt <= CW'(1);
        end else if (busy && !bus.bus_ack) begin
            busy_cnt <= busy_cnt + CW'(1);
        end
    end

    assign timeout = busy && !bus.bus_ack && (busy_cnt == CW'(TIMEOUT_CYCLES));
`else
    // Watchdog compiled out; the constant-false term keeps the parameter referenced.
    assign timeout = (TIMEOUT_CYCLES < 0);
`endif

    assign finish    = busy && (bus.bus_ack || timeout);
    assign inst_fin  = finish && (state == INST_BUSY);
    assign data_fin  = finish && (state == DATA_BUSY);
    assign rdata_now = bus.bus_ack ? bus.bus_rdata : '0;

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (grant_inst) begin
                    state_next = INST_BUSY;
                end else if (grant_data) begin
                    state_next = DATA_BUSY;
                end
            end
            INST_BUSY, DATA_BUSY: begin
                if (finish) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            last_grant   <= 1'b1;
            we_q         <= 1'b0;
            addr_q       <= '0;
            sel_q        <= '0;
            wdata_q      <= '0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
        end else begin
            state <= state_next;
            if (grant_inst) begin
                last_grant <= 1'b0;
                we_q       <= 1'b0;
                addr_q     <= bus.inst_addr;
                sel_q      <= '1;
                wdata_q    <= '0;
            end else if (grant_data) begin
                last_grant <= 1'b1;
                we_q       <= bus.data_we;
                addr_q     <= bus.data_addr;
                sel_q      <= bus.data_sel;
                wdata_q    <= bus.data_wdata;
            end
            if (inst_fin) begin
                inst_rdata_q <= rdata_now;
            end
            if (data_fin) begin
                data_rdata_q <= rdata_now;
            end
        end
    end

    assign bus.bus_req          = busy;
    assign bus.bus_we           = we_q;
    assign bus.bus_addr         = addr_q;
    assign bus.bus_sel          = sel_q;
    assign bus.bus_wdata        = wdata_q;
    assign bus.bus_err          = timeout;
    assign bus.inst_done        = inst_fin;
    assign bus.data_done        = data_fin;
    assign bus.inst_rdata       = inst_fin ? rdata_now : inst_rdata_q;
    assign bus.data_rdata       = data_fin ? rdata_now : data_rdata_q;
    assign bus.stallreq_for_bus = (bus.inst_req || bus.data_req) && !(inst_fin || data_fin);
endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed self-checking bench for sram_bus_arbiter (inputs driven 1 time unit after
// the rising edge, outputs sampled after settling within the same cycle).
module tb_sram_bus_arbiter;
    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;
    logic hang_bad;

    sram_bus_arbiter_if #(.AW(32), .DW(32)) bif ();

    sram_bus_arbiter #(
        .AW(32),
        .DW(32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic ireq, input logic [31:0] iaddr,
                                 input logic dreq, input logic dwe, input logic [31:0] daddr,
                                 input logic [3:0] dsel, input logic [31:0] dwdata);
        bif.inst_req   = ireq;
        bif.inst_addr  = iaddr;
        bif.data_req   = dreq;
        bif.data_we    = dwe;
        bif.data_addr  = daddr;
        bif.data_sel   = dsel;
        bif.data_wdata = dwdata;
    endtask

    // Called in an IDLE cycle with requests pending; serves one grant with a first-cycle ack.
    task automatic serveGrant(input string tag, input logic exp_data, input logic [31:0] exp_addr,
                              input logic [31:0] rdata);
        nextCycle();
        checkOutput({tag, "_busreq"}, bif.bus_req, 1);
        checkOutput({tag, "_addr"}, bif.bus_addr, exp_addr);
        checkOutput({tag, "_we"}, bif.bus_we, 0);
        bif.bus_ack   = 1'b1;
        bif.bus_rdata = rdata;
        #1;
        checkOutput({tag, "_idone"}, bif.inst_done, !exp_data);
        checkOutput({tag, "_ddone"}, bif.data_done, exp_data);
        checkOutput({tag, "_rdata"}, exp_data ? bif.data_rdata : bif.inst_rdata, rdata);
        nextCycle();
        bif.bus_ack = 1'b0;
        if (exp_data) bif.data_addr = bif.data_addr + 32'h10;
        else          bif.inst_addr = bif.inst_addr + 32'h10;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        hang_bad    = 1'b0;
        rst         = 1'b1;
        bif.bus_ack   = 1'b0;
        bif.bus_rdata = '0;
        applyStimulus(0, 32'h0, 0, 0, 32'h0, 4'h0, 32'h0);
        nextCycle();
        nextCycle();
        rst = 1'b0;
        #1;
        checkOutput("rst_busreq", bif.bus_req, 0);
        checkOutput("rst_busaddr", bif.bus_addr, 0);
        checkOutput("rst_bussel", bif.bus_sel, 0);
        checkOutput("rst_idone", bif.inst_done, 0);
        checkOutput("rst_ddone", bif.data_done, 0);
        checkOutput("rst_irdata", bif.inst_rdata, 0);
        checkOutput("rst_drdata", bif.data_rdata, 0);
        checkOutput("rst_err", bif.bus_err, 0);
        checkOutput("rst_stall", bif.stallreq_for_bus, 0);

        // Continuous contention out of reset: inst first, then strict alternation.
        applyStimulus(1, 32'h100, 1, 0, 32'h200, 4'hF, 32'h0);
        #1;
        checkOutput("rr_stall_idle", bif.stallreq_for_bus, 1);
        for (int i = 0; i < 6; i++) begin
            serveGrant($sformatf("rr%0d", i), (i % 2) == 1,
                       ((i % 2) == 1) ? 32'h200 + 32'(i / 2) * 32'h10 : 32'h100 + 32'(i / 2) * 32'h10,
                       32'hA000_0000 + 32'(i));
        end
        bif.inst_req = 1'b0;
        bif.data_req = 1'b0;
        nextCycle();
        checkOutput("rr_end_busreq", bif.bus_req, 0);

        // Store: bus fields must match while busy; ack in 2nd busy cycle.
        applyStimulus(0, 32'h0, 1, 1, 32'h2004, 4'b0011, 32'hDEADBEEF);
        nextCycle();
        checkOutput("st_busreq", bif.bus_req, 1);
        checkOutput("st_we", bif.bus_we, 1);
        checkOutput("st_addr", bif.bus_addr, 32'h2004);
        checkOutput("st_sel", bif.bus_sel, 4'b0011);
        checkOutput("st_wdata", bif.bus_wdata, 32'hDEADBEEF);
        checkOutput("st_nodone", bif.data_done, 0);
        nextCycle();
        checkOutput("st_addr2", bif.bus_addr, 32'h2004);
        checkOutput("st_wdata2", bif.bus_wdata, 32'hDEADBEEF);
        bif.bus_ack   = 1'b1;
        bif.bus_rdata = 32'h0BADF00D;
        #1;
        checkOutput("st_ddone", bif.data_done, 1);
        checkOutput("st_idone", bif.inst_done, 0);
        checkOutput("st_drdata", bif.data_rdata, 32'h0BADF00D);
        checkOutput("st_stall", bif.stallreq_for_bus, 0);
        nextCycle();
        bif.bus_ack  = 1'b0;
        bif.data_req = 1'b0;
        #1;
        checkOutput("st_after_busreq", bif.bus_req, 0);
        checkOutput("st_after_ddone", bif.data_done, 0);

        // Spurious ack in IDLE.
        nextCycle();
        bif.bus_ack   = 1'b1;
        bif.bus_rdata = 32'h13579BDF;
        #1;
        checkOutput("spur_idone", bif.inst_done, 0);
        checkOutput("spur_ddone", bif.data_done, 0);
        checkOutput("spur_drdata", bif.data_rdata, 32'h0BADF00D);
        nextCycle();
        bif.bus_ack = 1'b0;
        #1;
        checkOutput("spur_busreq", bif.bus_req, 0);

        // Single fetch: ack in 3rd busy cycle.
        applyStimulus(1, 32'h1000, 0, 0, 32'h0, 4'h0, 32'h0);
        #1;
        checkOutput("sf_c0_stall", bif.stallreq_for_bus, 1);
        checkOutput("sf_c0_busreq", bif.bus_req, 0);
        nextCycle();
        checkOutput("sf_c1_busreq", bif.bus_req, 1);
        checkOutput("sf_c1_addr", bif.bus_addr, 32'h1000);
        checkOutput("sf_c1_sel", bif.bus_sel, 4'hF);
        checkOutput("sf_c1_stall", bif.stallreq_for_bus, 1);
        nextCycle();
        checkOutput("sf_c2_busreq", bif.bus_req, 1);
        checkOutput("sf_c2_stall", bif.stallreq_for_bus, 1);
        checkOutput("sf_c2_idone", bif.inst_done, 0);
        nextCycle();
        bif.bus_ack   = 1'b1;
        bif.bus_rdata = 32'h24020005;
        #1;
        checkOutput("sf_c3_busreq", bif.bus_req, 1);
        checkOutput("sf_c3_idone", bif.inst_done, 1);
        checkOutput("sf_c3_irdata", bif.inst_rdata, 32'h24020005);
        checkOutput("sf_c3_stall", bif.stallreq_for_bus, 0);
        nextCycle();
        bif.bus_ack  = 1'b0;
        bif.inst_req = 1'b0;
        #1;
        checkOutput("sf_c4_busreq", bif.bus_req, 0);
        checkOutput("sf_c4_idone", bif.inst_done, 0);
        checkOutput("sf_c4_irdata", bif.inst_rdata, 32'h24020005);

        // Reset while a load is in flight; the late ack must be ignored.
        applyStimulus(0, 32'h0, 1, 0, 32'h3000, 4'hF, 32'h0);
        nextCycle();
        checkOutput("rm_busreq", bif.bus_req, 1);
        rst = 1'b1;
        nextCycle();
        rst           = 1'b0;
        bif.data_req  = 1'b0;
        bif.bus_ack   = 1'b1;
        bif.bus_rdata = 32'h55555555;
        #1;
        checkOutput("rm_busreq_after", bif.bus_req, 0);
        checkOutput("rm_ddone", bif.data_done, 0);
        checkOutput("rm_drdata", bif.data_rdata, 0);
        nextCycle();
        bif.bus_ack = 1'b0;
        #1;
        checkOutput("rm_idle", bif.bus_req, 0);

        // Fetch whose ack never arrives.
        applyStimulus(1, 32'h4000, 0, 0, 32'h0, 4'h0, 32'h0);
`ifdef SRAM_BUS_TIMEOUT_EN
        for (int c = 1; c <= 3; c++) begin
            nextCycle();
            checkOutput($sformatf("to_c%0d_err", c), bif.bus_err, 0);
            checkOutput($sformatf("to_c%0d_idone", c), bif.inst_done, 0);
        end
        nextCycle();
        checkOutput("to_c4_err", bif.bus_err, 1);
        checkOutput("to_c4_idone", bif.inst_done, 1);
        checkOutput("to_c4_irdata", bif.inst_rdata, 0);
        nextCycle();
        checkOutput("to_after_busreq", bif.bus_req, 0);
        checkOutput("to_after_err", bif.bus_err, 0);
        checkOutput("to_after_irdata", bif.inst_rdata, 0);
        // New request; an ack coinciding with the limit completes normally.
        bif.inst_addr = 32'h5000;
        for (int c = 1; c <= 3; c++) nextCycle();
        nextCycle();
        bif.bus_ack   = 1'b1;
        bif.bus_rdata = 32'h00000077;
        #1;
        checkOutput("tw_idone", bif.inst_done, 1);
        checkOutput("tw_err", bif.bus_err, 0);
        checkOutput("tw_irdata", bif.inst_rdata, 32'h77);
        nextCycle();
        bif.bus_ack  = 1'b0;
        bif.inst_req = 1'b0;
`else
        for (int c = 0; c < 1000; c++) begin
            nextCycle();
            if (bif.bus_err || bif.inst_done || !bif.bus_req) hang_bad = 1'b1;
        end
        checkOutput("hang_stayed_busy", hang_bad, 0);
        checkOutput("hang_busreq", bif.bus_req, 1);
        checkOutput("hang_err", bif.bus_err, 0);
        bif.bus_ack   = 1'b1;
        bif.bus_rdata = 32'h00000077;
        #1;
        checkOutput("hang_release_idone", bif.inst_done, 1);
        nextCycle();
        bif.bus_ack  = 1'b0;
        bif.inst_req = 1'b0;
`endif
        nextCycle();
        checkOutput("final_busreq", bif.bus_req, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
